corepwm_tach_gen: RTL and testbench

Tachometer pulse generator, the transmit-side counterpart of the CorePWM tach input channel. It emits a programmable fan-tach waveform on TACHOUT, with period and active-phase width counted in tach_cnt_clk strobe ticks. It is used for fan emulation and for loopback self-test of the tach measurement channels. Runs continuously or for a counted burst of periods.

---
 rtl/corepwm_tach_gen_pkg.sv | 16 +
 rtl/corepwm_tach_gen_if.sv | 54 +++++
 rtl/corepwm_tach_gen_shadow.sv | 51 +++++
 rtl/corepwm_tach_gen.sv | 141 ++++++++++++++
 tb/tb_corepwm_tach_gen.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/corepwm_tach_gen_pkg.sv
// corepwm_tach_gen shared types: FSM states, minimum period, default widths.
// Optional stall emulation is enabled by defining TACHGEN_STALL_EN.
package corepwm_tach_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int BURST_W_DEF     = 8;
  localparam int TACH_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    INACTIVE = 2'd2,
    STALL    = 2'd3
  } tach_state_e;

endpackage

// File: rtl/corepwm_tach_gen_if.sv
// Control/status bundle of the tach pulse generator.
// stall_req exists only when TACHGEN_STALL_EN is defined.
interface corepwm_tach_gen_if
  import corepwm_tach_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_W_DEF,
  parameter int BURST_WIDTH = BURST_W_DEF
);

  logic                   tach_cnt_clk;
  logic                   TACHGEN_EN;
  logic                   TACHGEN_MODE;
  logic                   TACH_EDGE;
  logic [CNT_WIDTH-1:0]   TACHPERIOD;
  logic [CNT_WIDTH-1:0]   TACHHIGH;
  logic [BURST_WIDTH-1:0] TACHBURST;
  logic                   burst_start;
  logic                   TACHOUT;
  logic                   busy;
  logic                   period_done;
  logic                   burst_done;
`ifdef TACHGEN_STALL_EN
  logic                   stall_req;

  modport master (
    output tach_cnt_clk, TACHGEN_EN, TACHGEN_MODE,
    output TACH_EDGE, TACHPERIOD, TACHHIGH,
    output TACHBURST, burst_start, stall_req,
    input  TACHOUT, busy, period_done, burst_done
  );

  modport slave (
    input  tach_cnt_clk, TACHGEN_EN, TACHGEN_MODE,
    input  TACH_EDGE, TACHPERIOD, TACHHIGH,
    input  TACHBURST, burst_start, stall_req,
    output TACHOUT, busy, period_done, burst_done
  );
`else
  modport master (
    output tach_cnt_clk, TACHGEN_EN, TACHGEN_MODE,
    output TACH_EDGE, TACHPERIOD, TACHHIGH,
    output TACHBURST, burst_start,
    input  TACHOUT, busy, period_done, burst_done
  );

  modport slave (
    input  tach_cnt_clk, TACHGEN_EN, TACHGEN_MODE,
    input  TACH_EDGE, TACHPERIOD, TACHHIGH,
    input  TACHBURST, burst_start,
    output TACHOUT, busy, period_done, burst_done
  );
`endif

endinterface

// File: rtl/corepwm_tach_gen_shadow.sv
// Period/active-width shadow registers with clamping, plus the polarity
// register that tracks TACH_EDGE only while the generator is idle.
module corepwm_tach_shadow
  import corepwm_tach_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 idle,
  input  logic                 edge_sel,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] high,
  output logic [CNT_WIDTH-1:0] per_s,
  output logic [CNT_WIDTH-1:0] hi_s,
  output logic                 pol_q
);

  localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(TACH_MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] per_c;
  logic [CNT_WIDTH-1:0] hi_c;

  // Both phases are always at least one tick long.
  always_comb begin
    per_c = (period < MIN_P) ? MIN_P : period;
    hi_c  = high;
    if (high == '0)
      hi_c = ONE;
    else if (high >= per_c)
      hi_c = per_c - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_s <= MIN_P;
      hi_s  <= ONE;
      pol_q <= 1'b1;
    end else begin
      if (load) begin
        per_s <= per_c;
        hi_s  <= hi_c;
      end
      if (idle)
        pol_q <= edge_sel;
    end
  end

endmodule

// File: rtl/corepwm_tach_gen.sv
// Tach pulse generator: continuous or counted-burst fan-tach waveform.
// Define TACHGEN_STALL_EN to add the stall_req fan-stall emulation.
module corepwm_tach_gen
  import corepwm_tach_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_W_DEF,
  parameter int BURST_WIDTH = BURST_W_DEF
) (
  input logic               PCLK,
  input logic               PRESETN,
  corepwm_tach_gen_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0]   C1 = CNT_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] B1 = BURST_WIDTH'(1);

  tach_state_e            state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [BURST_WIDTH-1:0] bcnt_q;
  logic                   pend_q;
  logic                   active_q;
  logic                   pd_q;
  logic                   bd_q;
  logic [CNT_WIDTH-1:0]   per_s;
  logic [CNT_WIDTH-1:0]   hi_s;
  logic                   pol_q;

  logic tick, stall, start_ok, last, go_on;
  logic per_end, load, burst_req;

`ifdef TACHGEN_STALL_EN
  assign stall = bus.stall_req;
`else
  assign stall = 1'b0;
`endif

  assign tick     = bus.tach_cnt_clk;
  assign start_ok = pend_q | (~bus.TACHGEN_MODE & bus.TACHGEN_EN);
  assign last     = bus.TACHGEN_MODE & (bcnt_q <= B1);
  assign go_on    = bus.TACHGEN_EN & ~last;
  assign per_end  = tick && state_q == INACTIVE
                 && cnt_q == per_s - C1;
  assign burst_req = state_q == IDLE && bus.burst_start
                  && bus.TACHGEN_EN && bus.TACHGEN_MODE && !pend_q;

  // Shadows reload at every period start, including stall recovery.
  assign load = tick && ((state_q == IDLE && start_ok)
             || (per_end && go_on && !stall)
             || (state_q == STALL && !stall));

  corepwm_tach_shadow #(.CNT_WIDTH(CNT_WIDTH)) u_shadow (
    .clk      (PCLK),
    .rst_n    (PRESETN),
    .load     (load),
    .idle     (state_q == IDLE),
    .edge_sel (bus.TACH_EDGE),
    .period   (bus.TACHPERIOD),
    .high     (bus.TACHHIGH),
    .per_s    (per_s),
    .hi_s     (hi_s),
    .pol_q    (pol_q)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      pend_q   <= 1'b0;
      active_q <= 1'b0;
      pd_q     <= 1'b0;
      bd_q     <= 1'b0;
    end else begin
      pd_q <= 1'b0;
      bd_q <= 1'b0;
      if (burst_req) begin
        if (bus.TACHBURST == '0) begin
          bd_q <= 1'b1;
        end else begin
          pend_q <= 1'b1;
          bcnt_q <= bus.TACHBURST;
        end
      end
      if (tick) begin
        unique case (state_q)
          IDLE: begin
            if (start_ok) begin
              state_q  <= ACTIVE;
              active_q <= 1'b1;
              cnt_q    <= '0;
              pend_q   <= 1'b0;
            end
          end
          ACTIVE: begin
            cnt_q <= cnt_q + C1;
            if (cnt_q == hi_s - C1) begin
              state_q  <= INACTIVE;
              active_q <= 1'b0;
            end
          end
          INACTIVE: begin
            if (per_end) begin
              pd_q <= 1'b1;
              if (bus.TACHGEN_MODE && bcnt_q != '0)
                bcnt_q <= bcnt_q - B1;
              if (!go_on) begin
                state_q <= IDLE;
                bd_q    <= last & bus.TACHGEN_EN;
              end else if (stall) begin
                state_q <= STALL;
              end else begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
                cnt_q    <= '0;
              end
            end else begin
              cnt_q <= cnt_q + C1;
            end
          end
          default: begin
`ifdef TACHGEN_STALL_EN
            if (!stall) begin
              state_q  <= ACTIVE;
              active_q <= 1'b1;
              cnt_q    <= '0;
            end
`else
            state_q <= IDLE;
`endif
          end
        endcase
      end
    end
  end

  assign bus.TACHOUT     = active_q ^ ~pol_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.period_done = pd_q;
  assign bus.burst_done  = bd_q;

endmodule

// File: tb/tb_corepwm_tach_gen.sv
// Directed bench for corepwm_tach_gen: continuous, clamp, reload, prescale,
// burst, empty burst and asynchronous reset scenarios.
module tb_corepwm_tach_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  corepwm_tach_gen_if #(.CNT_WIDTH(16), .BURST_WIDTH(8)) bus ();

  corepwm_tach_gen #(.CNT_WIDTH(16), .BURST_WIDTH(8)) dut (
    .PCLK    (clk),
    .PRESETN (rst_n),
    .bus     (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tach_cnt_clk = 1'b1;
    bus.TACHGEN_EN   = 1'b0;
    bus.TACHGEN_MODE = 1'b0;
    bus.TACH_EDGE    = 1'b1;
    bus.TACHPERIOD   = '0;
    bus.TACHHIGH     = '0;
    bus.TACHBURST    = '0;
    bus.burst_start  = 1'b0;
`ifdef TACHGEN_STALL_EN
    bus.stall_req    = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    step();
    if (bus.TACHOUT !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_out got %b want 0", bus.TACHOUT);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    vectors++;
    if (bus.period_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pd got %b want 0", bus.period_done);
    end
    vectors++;
    if (bus.burst_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_bd got %b want 0", bus.burst_done);
    end
    vectors++;
  endtask

  // 10/3 waveform; enable drops mid-ACTIVE and the period still completes.
  task automatic test_continuous();
    logic eo, ep, eb;
    bus.TACHPERIOD = 16'd10;
    bus.TACHHIGH   = 16'd3;
    bus.TACHGEN_EN = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      step();
      eo = (j < 40) && (j % 10 < 3);
      ep = (j > 0) && (j % 10 == 0);
      eb = (j < 40);
      if (bus.TACHOUT !== eo) begin
        miscompares++;
        $display("FAIL cont_out j=%0d got %b want %b", j, bus.TACHOUT, eo);
      end
      vectors++;
      if (bus.period_done !== ep) begin
        miscompares++;
        $display("FAIL cont_pd j=%0d got %b want %b", j, bus.period_done, ep);
      end
      vectors++;
      if (bus.busy !== eb) begin
        miscompares++;
        $display("FAIL cont_busy j=%0d got %b want %b", j, bus.busy, eb);
      end
      vectors++;
      if (j == 31) bus.TACHGEN_EN = 1'b0;
    end
  endtask

  task automatic test_clamp();
    logic eo, ep, eb;
    bus.TACHPERIOD = 16'd0;
    bus.TACHHIGH   = 16'd0;
    bus.TACHGEN_EN = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      step();
      eo = (j < 6) && (j % 2 == 0);
      ep = (j > 0) && (j % 2 == 0);
      eb = (j < 6);
      if (bus.TACHOUT !== eo || bus.period_done !== ep || bus.busy !== eb) begin
        miscompares++;
        $display("FAIL clamp_min j=%0d got %b%b%b want %b%b%b", j,
                 bus.TACHOUT, bus.period_done, bus.busy, eo, ep, eb);
      end
      vectors++;
      if (j == 5) bus.TACHGEN_EN = 1'b0;
    end
    bus.TACHPERIOD = 16'd20;
    bus.TACHHIGH   = 16'd50;
    bus.TACHGEN_EN = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      step();
      eo = (j < 40) && (j % 20 < 19);
      ep = (j == 20) || (j == 40);
      eb = (j < 40);
      if (bus.TACHOUT !== eo || bus.period_done !== ep || bus.busy !== eb) begin
        miscompares++;
        $display("FAIL clamp_hi j=%0d got %b%b%b want %b%b%b", j,
                 bus.TACHOUT, bus.period_done, bus.busy, eo, ep, eb);
      end
      vectors++;
      if (j == 21) bus.TACHGEN_EN = 1'b0;
    end
  endtask

  // New TACHPERIOD written mid-period applies from the following period.
  task automatic test_period_change();
    logic eo, ep, eb;
    bus.TACHPERIOD = 16'd8;
    bus.TACHHIGH   = 16'd2;
    bus.TACHGEN_EN = 1'b1;
    for (int j = 0; j <= 19; j++) begin
      step();
      eo = (j inside {0, 1, 8, 9, 13, 14});
      ep = (j inside {8, 13, 18});
      eb = (j < 18);
      if (bus.TACHOUT !== eo || bus.period_done !== ep || bus.busy !== eb) begin
        miscompares++;
        $display("FAIL perchg j=%0d got %b%b%b want %b%b%b", j,
                 bus.TACHOUT, bus.period_done, bus.busy, eo, ep, eb);
      end
      vectors++;
      if (j == 3) bus.TACHPERIOD = 16'd5;
      if (j == 14) bus.TACHGEN_EN = 1'b0;
    end
  endtask

  task automatic test_prescale();
    logic eo, ep, eb;
    bus.TACHPERIOD = 16'd3;
    bus.TACHHIGH   = 16'd1;
    bus.TACHGEN_EN = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      bus.tach_cnt_clk = (k % 2 == 0);
      step();
      eo = (k < 12) && (k % 6 < 2);
      ep = (k == 6) || (k == 12);
      eb = (k < 12);
      if (bus.TACHOUT !== eo || bus.period_done !== ep || bus.busy !== eb) begin
        miscompares++;
        $display("FAIL presc k=%0d got %b%b%b want %b%b%b", k,
                 bus.TACHOUT, bus.period_done, bus.busy, eo, ep, eb);
      end
      vectors++;
      if (k == 7) bus.TACHGEN_EN = 1'b0;
    end
    bus.tach_cnt_clk = 1'b1;
  endtask

  // Three active-low pulses; a second request while busy must be dropped.
  task automatic test_burst();
    logic eo, ep, ed, eb;
    bus.TACH_EDGE    = 1'b0;
    bus.TACHGEN_MODE = 1'b1;
    bus.TACHPERIOD   = 16'd4;
    bus.TACHHIGH     = 16'd1;
    bus.TACHBURST    = 8'd3;
    bus.TACHGEN_EN   = 1'b1;
    step();
    if (bus.TACHOUT !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_idle got %b%b want 10", bus.TACHOUT, bus.busy);
    end
    vectors++;
    bus.burst_start = 1'b1;
    step();
    bus.burst_start = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      step();
      eo = !((j < 12) && (j % 4 == 0));
      ep = (j inside {4, 8, 12});
      ed = (j == 12);
      eb = (j < 12);
      if (bus.TACHOUT !== eo || bus.period_done !== ep
          || bus.burst_done !== ed || bus.busy !== eb) begin
        miscompares++;
        $display("FAIL burst j=%0d got %b%b%b%b want %b%b%b%b", j,
                 bus.TACHOUT, bus.period_done, bus.burst_done, bus.busy,
                 eo, ep, ed, eb);
      end
      vectors++;
      bus.burst_start = (j == 5);
    end
  endtask

  task automatic test_burst_zero();
    bus.TACHBURST   = 8'd0;
    bus.burst_start = 1'b1;
    step();
    bus.burst_start = 1'b0;
    if (bus.burst_done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bzero_done got %b%b want 10", bus.burst_done, bus.busy);
    end
    vectors++;
    for (int j = 0; j < 4; j++) begin
      step();
      if (bus.burst_done !== 1'b0 || bus.busy !== 1'b0
          || bus.TACHOUT !== 1'b1) begin
        miscompares++;
        $display("FAIL bzero_after j=%0d got %b%b%b want 001", j,
                 bus.burst_done, bus.busy, bus.TACHOUT);
      end
      vectors++;
    end
    bus.TACHGEN_EN = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.TACHGEN_MODE = 1'b0;
    bus.TACH_EDGE    = 1'b0;
    bus.TACHPERIOD   = 16'd10;
    bus.TACHHIGH     = 16'd3;
    bus.TACHGEN_EN   = 1'b1;
    for (int j = 0; j <= 5; j++) step();
    if (bus.TACHOUT !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_pre got %b%b want 11", bus.TACHOUT, bus.busy);
    end
    vectors++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.TACHOUT !== 1'b0 || bus.busy !== 1'b0
        || bus.period_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_async got %b%b%b want 000",
               bus.TACHOUT, bus.busy, bus.period_done);
    end
    vectors++;
    @(negedge clk);
    bus.TACHGEN_EN = 1'b0;
    bus.TACH_EDGE  = 1'b1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_clamp();
    test_period_change();
    test_prescale();
    test_burst();
    test_burst_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
